// File: rtl/router_reg_pkg.sv
// Shared router definitions: byte width, address field layout and the reserved address.
// Imported by the FSM, synchronizer, FIFO and this datapath register stage.
package router_reg_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef logic [DATA_W-1:0] pkt_byte_t;

  function automatic logic addr_ok(input pkt_byte_t b);
    return b[ADDR_W-1:0] != ADDR_INVALID;
  endfunction
endpackage

// File: rtl/router_reg_if.sv
// Bundle between the router FSM/source side (master) and the datapath register stage (slave).
interface router_reg_if #(
  parameter int DATA_W = router_reg_pkg::DATA_W
);
  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic              fifo_full;
  logic              detect_addr;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic [DATA_W-1:0] dout;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_addr, lfd_state,
           ld_state, laf_state, full_state, rst_int_reg,
    input  parity_done, low_pkt_valid, err, dout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_addr, lfd_state,
           ld_state, laf_state, full_state, rst_int_reg,
    output parity_done, low_pkt_valid, err, dout
  );
endinterface

// File: rtl/router_parity.sv
// Running XOR parity accumulator: clear has priority over accumulate.
module router_parity #(
  parameter int DATA_W = router_reg_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_par
);
  logic [DATA_W-1:0] r_par;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_par <= '0;
    end else if (i_clr) begin
      r_par <= '0;
    end else if (i_en) begin
      r_par <= r_par ^ i_data;
    end
  end

  assign o_par = r_par;
endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header/stall byte holding, FIFO write byte selection,
// running and received parity, and the parity_done / low_pkt_valid / err status flags.
module router_reg #(
  parameter int DATA_W = router_reg_pkg::DATA_W
) (
  input  logic        clock,
  input  logic        resetn,
  router_reg_if.slave bus
);
  import router_reg_pkg::*;

  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_hdr;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_pkt_par;
  logic              r_parity_done;
  logic              r_low_pkt_valid;
  logic              r_err;

  logic [DATA_W-1:0] w_int_par;
  logic [DATA_W-1:0] w_par_data;
  logic              w_par_en;
  logic              w_hdr_load;
  logic              w_pd_set;

  assign w_hdr_load = bus.detect_addr & bus.pkt_valid &
                      (bus.data_in[ADDR_W-1:0] != ADDR_INVALID);

  // The parity byte itself (pkt_valid low) never enters the running parity.
  assign w_par_en   = bus.lfd_state | (bus.ld_state & bus.pkt_valid & !bus.full_state);
  assign w_par_data = bus.lfd_state ? r_hdr : bus.data_in;

  // Second term covers a parity byte that was stalled and is only written out in LOAD_AFTER_FULL.
  assign w_pd_set = (bus.ld_state & !bus.fifo_full & !bus.pkt_valid) |
                    (bus.laf_state & r_low_pkt_valid & !r_parity_done);

  router_parity #(.DATA_W(DATA_W)) u_parity (
    .clock  (clock),
    .resetn (resetn),
    .i_clr  (bus.detect_addr),
    .i_en   (w_par_en),
    .i_data (w_par_data),
    .o_par  (w_int_par)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_hdr     <= '0;
      r_hold    <= '0;
      r_pkt_par <= '0;
      r_dout    <= '0;
    end else begin
      if (w_hdr_load) r_hdr <= bus.data_in;
      if (bus.ld_state && bus.fifo_full) r_hold <= bus.data_in;
      if (bus.ld_state && !bus.pkt_valid) r_pkt_par <= bus.data_in;

      if (bus.lfd_state) begin
        r_dout <= r_hdr;
      end else if (bus.ld_state && !bus.fifo_full) begin
        r_dout <= bus.data_in;
      end else if (bus.laf_state) begin
        r_dout <= r_hold;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_low_pkt_valid <= 1'b0;
      r_parity_done   <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      if (bus.rst_int_reg) begin
        r_low_pkt_valid <= 1'b0;
      end else if (bus.ld_state && !bus.pkt_valid) begin
        r_low_pkt_valid <= 1'b1;
      end

      if (bus.detect_addr) begin
        r_parity_done <= 1'b0;
      end else if (w_pd_set) begin
        r_parity_done <= 1'b1;
      end

      // Compared only once parity_done is registered, so pkt_par is already settled.
      if (bus.detect_addr) begin
        r_err <= 1'b0;
      end else if (r_parity_done) begin
        r_err <= (w_int_par != r_pkt_par);
      end
    end
  end

  assign bus.dout          = r_dout;
  assign bus.parity_done   = r_parity_done;
  assign bus.low_pkt_valid = r_low_pkt_valid;
  assign bus.err           = r_err;
endmodule
